// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame sizes and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // Full line frame is start + 8 data + parity + stop; host latches all but start.
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_TX_BITS    = 10;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a PS/2 command source and the host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_ok, err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_ok, err
  );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Three-flop synchroniser for a raw PS/2 line with a one-cycle falling-edge strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);
  logic [2:0] sync;

  // Idle lines are pulled high, so resetting to 1 avoids a spurious fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[1:0], din};
  end

  assign level = sync[2];
  assign fall  = sync[2] & ~sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 10 device-clocked bits, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(PS2_TX_BITS - 1);

  ps2_state_t             state;
  logic [PS2_TX_BITS-1:0] frame;
  logic [3:0]             bit_idx;
  logic [INH_W-1:0]       inh_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic tx_ready_q, busy_q, done_q, ack_ok_q, err_q;
  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_data_in),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame       <= '0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx.tx_valid) begin
            frame      <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            bit_idx    <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end
        RTS: begin
          ps2_clk_oe <= 1'b0;
          bit_idx    <= '0;
          to_cnt     <= '0;
          state      <= SEND;
        end
        SEND, ACK, WAIT_IDLE: begin
          // Timeout wins over any fall arriving in the same cycle.
          if (to_cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            err_q       <= 1'b1;
            ack_ok_q    <= 1'b0;
            done_q      <= 1'b1;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (state == SEND && clk_fall) begin
              ps2_data_oe <= ~frame[bit_idx];
              bit_idx     <= bit_idx + 4'd1;
              if (bit_idx == IDX_LAST) state <= ACK;
            end else if (state == ACK && clk_fall) begin
              if (data_lvl) err_q    <= 1'b1;
              else          ack_ok_q <= 1'b1;
              state <= WAIT_IDLE;
            end else if (state == WAIT_IDLE && clk_lvl && data_lvl) begin
              done_q     <= 1'b1;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.tx_ready = tx_ready_q;
  assign tx.busy     = busy_q;
  assign tx.done     = done_q;
  assign tx.ack_ok   = ack_ok_q;
  assign tx.err      = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line model and a simple PS/2 device.
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk, ps2_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic d_ack, d_err, d_clk_oe, d_data_oe;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx          (tx_if.slave),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  assign ps2_clk  = ~ps2_clk_oe & dev_clk;
  assign ps2_data = ~ps2_data_oe & ~dev_data_low;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tx_if.done) begin
      done_cnt++;
      done_cyc  = cyc;
      d_ack     = tx_if.ack_ok;
      d_err     = tx_if.err;
      d_clk_oe  = ps2_clk_oe;
      d_data_oe = ps2_data_oe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d, input bit keep);
    @(negedge clk);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) tx_if.tx_valid = 1'b0;
    check_eq("acc_busy", 32'(tx_if.busy), 1);
    check_eq("acc_ready", 32'(tx_if.tx_ready), 0);
    check_eq("acc_ack_clr", 32'(tx_if.ack_ok), 0);
    check_eq("acc_err_clr", 32'(tx_if.err), 0);
  endtask

  // Starts #1 after the accept edge; returns at the negedge of the done cycle.
  task automatic frame_body(input logic [7:0] d, input logic par, input bit ack);
    int n;
    int base;
    logic [10:0] smp;
    logic [10:0] exp_bits;
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("inhibit_len", n, 20);
    check_eq("rts_clk_oe", 32'(ps2_clk_oe), 1);
    check_eq("rts_data_oe", 32'(ps2_data_oe), 1);
    @(posedge clk); #1;
    check_eq("clk_release", 32'(ps2_clk_oe), 0);
    check_eq("start_hold", 32'(ps2_data_oe), 1);
    base = done_cnt;
    repeat (10) @(negedge clk);
    smp[0] = ps2_data;
    for (int i = 1; i < 11; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      smp[i] = ps2_data;
      repeat (20) @(negedge clk);
    end
    exp_bits = {1'b1, par, d, 1'b0};
    check_eq("frame_bits", 32'(smp), 32'(exp_bits));
    check_eq("busy_in_ack", 32'(tx_if.busy), 1);
    dev_data_low = ack;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
    n = 0;
    while (done_cnt == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_count", done_cnt - base, 1);
    check_eq("done_ack_ok", 32'(d_ack), 32'(ack));
    check_eq("done_err", 32'(d_err), 32'(!ack));
    check_eq("done_clk_oe", 32'(d_clk_oe), 0);
    check_eq("done_data_oe", 32'(d_data_oe), 0);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    check_eq("done_pulse_1cyc", 32'(tx_if.done), 0);
    check_eq("idle_ready", 32'(tx_if.tx_ready), 1);
    check_eq("idle_busy", 32'(tx_if.busy), 0);
  endtask

  initial begin
    int n;
    int rel;
    int base;
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;

    repeat (3) @(posedge clk); #1;
    check_eq("rst_ready", 32'(tx_if.tx_ready), 1);
    check_eq("rst_busy", 32'(tx_if.busy), 0);
    check_eq("rst_done", 32'(tx_if.done), 0);
    check_eq("rst_ack_ok", 32'(tx_if.ack_ok), 0);
    check_eq("rst_err", 32'(tx_if.err), 0);
    check_eq("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check_eq("rst_data_oe", 32'(ps2_data_oe), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 0xED and 0xF4 with device ACK
    accept(8'hED, 1'b0); frame_body(8'hED, 1'b1, 1'b1); after_done();
    accept(8'hF4, 1'b0); frame_body(8'hF4, 1'b0, 1'b1); after_done();
    // 0x00 with no ACK from the device
    accept(8'h00, 1'b0); frame_body(8'h00, 1'b1, 1'b0); after_done();
    check_eq("nack_err_hold", 32'(tx_if.err), 1);

    // Device never clocks: timeout measured from clock release
    accept(8'hF4, 1'b0);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("to_release_seen", 32'(ps2_clk_oe), 0);
    rel  = cyc;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_done_count", done_cnt - base, 1);
    check_eq("to_latency", done_cyc - rel, 2000);
    check_eq("to_err", 32'(d_err), 1);
    check_eq("to_ack_ok", 32'(d_ack), 0);
    check_eq("to_clk_oe", 32'(d_clk_oe), 0);
    check_eq("to_data_oe", 32'(d_data_oe), 0);
    after_done();

    // Asynchronous reset after fall 4 of a 0xFF send
    accept(8'hFF, 1'b0);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_rst_busy", 32'(tx_if.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_clk_oe", 32'(ps2_clk_oe), 0);
    check_eq("arst_data_oe", 32'(ps2_data_oe), 0);
    check_eq("arst_busy", 32'(tx_if.busy), 0);
    check_eq("arst_ready", 32'(tx_if.tx_ready), 1);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_eq("post_rst_ready", 32'(tx_if.tx_ready), 1);
    check_eq("post_rst_busy", 32'(tx_if.busy), 0);
    accept(8'hF4, 1'b0); frame_body(8'hF4, 1'b0, 1'b1); after_done();

    // Back-to-back with tx_valid held, plus a mid-frame toggle
    accept(8'hED, 1'b1);
    tx_if.tx_data = 8'h02;
    fork
      frame_body(8'hED, 1'b1, 1'b1);
      begin
        repeat (100) @(negedge clk);
        tx_if.tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        tx_if.tx_valid = 1'b1;
      end
    join
    @(posedge clk); #1;
    tx_if.tx_valid = 1'b0;
    check_eq("b2b_gap", cyc - done_cyc, 1);
    check_eq("b2b_inhibit", 32'(ps2_clk_oe), 1);
    check_eq("b2b_busy", 32'(tx_if.busy), 1);
    check_eq("b2b_ack_clr", 32'(tx_if.ack_ok), 0);
    frame_body(8'h02, 1'b0, 1'b1); after_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
